// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares one single-port synchronous VRAM between the CPU (through a small
//   write buffer) and the VGA scan-out fetcher. VGA reads always win, CPU reads
//   wait for an empty buffer, and buffered writes drain in otherwise free cycles.
//   VGA reads forward data from still-buffered writes. Read latency is fixed at
//   three cycles from grant to valid pulse for both requesters.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   cpu_we/cpu_re         CPU write / read request (read held until cpu_rvalid)
//   cpu_address/cpu_data  CPU word address and write data
//   cpu_stall             CPU must hold its current access (combinational)
//   cpu_rdata/cpu_rvalid  CPU read data (held) and one-cycle valid pulse
//   vga_req/vga_address   single-cycle VGA fetch request and word address
//   vga_data/vga_valid    VGA fetch data and one-cycle valid pulse
//   mem_we/mem_address/mem_wdata  registered VRAM port
//   mem_rdata             VRAM read data, valid the cycle after mem_address
module vram_arbiter #(
   parameter int N     = 32,
   parameter int AW    = 6,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_we,
   input  logic          cpu_re,
   input  logic [AW-1:0] cpu_address,
   input  logic [N-1:0]  cpu_data,
   output logic          cpu_stall,
   output logic [N-1:0]  cpu_rdata,
   output logic          cpu_rvalid,
   input  logic          vga_req,
   input  logic [AW-1:0] vga_address,
   output logic [N-1:0]  vga_data,
   output logic          vga_valid,
   output logic          mem_we,
   output logic [AW-1:0] mem_address,
   output logic [N-1:0]  mem_wdata,
   input  logic [N-1:0]  mem_rdata
);
   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_VGA = 2'd1, TAG_CPU = 2'd2} tag_t;

   logic [AW-1:0] buf_addr [DEPTH];
   logic [N-1:0]  buf_data [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   logic          empty, full, push, rd_busy;
   logic          grant_vga, grant_cpu, grant_drain;
   logic [AW-1:0] drain_addr;
   logic [N-1:0]  drain_data;
   tag_t          grant_tag, tag1, tag2;
   logic          fwd_hit, hit1, hit2;
   logic [N-1:0]  fwd_data, hit_data1, hit_data2;
   logic [PW-1:0] fwd_idx;

   assign empty     = (count == '0);
   assign full      = (count == (PW+1)'(DEPTH));
   assign push      = cpu_we & ~full;
   assign cpu_stall = (cpu_we & full) | (cpu_re & ~cpu_rvalid);

   // Arbitration: VGA, then CPU read (empty buffer, nothing in flight), then drain.
   // A write arriving into an empty buffer is drained in the same cycle it is
   // pushed, so an idle arbiter puts it on the VRAM port one cycle later.
   always_comb begin
      grant_vga   = vga_req;
      grant_cpu   = ~vga_req & cpu_re & ~cpu_we & empty & ~rd_busy;
      grant_drain = ~vga_req & ~grant_cpu & (~empty | cpu_we);
      grant_tag   = TAG_NONE;
      if (grant_vga)
         grant_tag = TAG_VGA;
      else if (grant_cpu)
         grant_tag = TAG_CPU;
      drain_addr = empty ? cpu_address : buf_addr[rd_ptr];
      drain_data = empty ? cpu_data    : buf_data[rd_ptr];
   end

   // Forwarding: scan live entries oldest to youngest so the youngest match wins.
   // Uses buffer contents before this cycle's push.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_idx  = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         fwd_idx = rd_ptr + PW'(k);
         if (k < 32'(count) && buf_addr[fwd_idx] == vga_address) begin
            fwd_hit  = 1'b1;
            fwd_data = buf_data[fwd_idx];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (grant_drain)
            rd_ptr <= rd_ptr + PW'(1);
         unique case ({push, grant_drain})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_addr[wr_ptr] <= cpu_address;
         buf_data[wr_ptr] <= cpu_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_we      <= 1'b0;
         mem_address <= '0;
         mem_wdata   <= '0;
      end else begin
         mem_we <= grant_drain;
         if (grant_vga)
            mem_address <= vga_address;
         else if (grant_cpu)
            mem_address <= cpu_address;
         else if (grant_drain) begin
            mem_address <= drain_addr;
            mem_wdata   <= drain_data;
         end
      end
   end

   // Two-stage tag pipe aligns routing with mem_rdata; forwarded data rides along.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag1       <= TAG_NONE;
         tag2       <= TAG_NONE;
         hit1       <= 1'b0;
         hit2       <= 1'b0;
         hit_data1  <= '0;
         hit_data2  <= '0;
         vga_valid  <= 1'b0;
         vga_data   <= '0;
         cpu_rvalid <= 1'b0;
         cpu_rdata  <= '0;
         rd_busy    <= 1'b0;
      end else begin
         tag1      <= grant_tag;
         tag2      <= tag1;
         hit1      <= grant_vga & fwd_hit;
         hit2      <= hit1;
         hit_data1 <= fwd_data;
         hit_data2 <= hit_data1;
         vga_valid  <= (tag2 == TAG_VGA);
         cpu_rvalid <= (tag2 == TAG_CPU);
         if (tag2 == TAG_VGA)
            vga_data <= hit2 ? hit_data2 : mem_rdata;
         if (tag2 == TAG_CPU)
            cpu_rdata <= mem_rdata;
         if (grant_cpu)
            rd_busy <= 1'b1;
         else if (cpu_rvalid)
            rd_busy <= 1'b0;
      end
   end
endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: a VRAM model, a transaction-level reference
// (write queue + memory image, results scheduled by cycle) and directed plus
// randomized stimulus.
module tb_vram_arbiter;
   localparam int N     = 32;
   localparam int AW    = 6;
   localparam int DEPTH = 4;
   localparam int WORDS = 1 << AW;

   logic          clk = 1'b0;
   logic          reset, cpu_we, cpu_re, vga_req;
   logic [AW-1:0] cpu_address, vga_address, mem_address;
   logic [N-1:0]  cpu_data, cpu_rdata, vga_data, mem_wdata, mem_rdata;
   logic          cpu_stall, cpu_rvalid, vga_valid, mem_we;

   always #5 clk = ~clk;

   vram_arbiter #(.N(N), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_address(cpu_address), .cpu_data(cpu_data),
      .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .vga_req(vga_req), .vga_address(vga_address), .vga_data(vga_data), .vga_valid(vga_valid),
      .mem_we(mem_we), .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // VRAM: synchronous write, synchronous read
   logic          ram_load;
   logic [N-1:0]  ram      [WORDS];
   logic [N-1:0]  ram_init [WORDS];
   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < WORDS; i++) ram[i] <= ram_init[i];
      end else begin
         if (mem_we) ram[mem_address] <= mem_wdata;
         mem_rdata <= ram[mem_address];
      end
   end

   // Reference model
   typedef struct { logic [AW-1:0] a; logic [N-1:0] d; } wr_t;
   typedef struct {
      bit mem_we; logic [AW-1:0] mem_a; logic [N-1:0] mem_d;
      bit vv; logic [N-1:0] vd; bit cv; logic [N-1:0] cd;
   } slot_t;

   wr_t           q[$];
   logic [N-1:0]  ram_m [WORDS];
   slot_t         ring [8];
   int            cyc = 0;
   int            busy_until;
   logic [AW-1:0] cur_addr;
   logic [N-1:0]  cur_wdata, cur_crd;
   bit            pend_v;
   logic [AW-1:0] pend_a;
   logic [N-1:0]  pend_d;
   bit            last_stall;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < 8; i++) ring[i] = '{default: '0};
      cur_addr   = '0;
      cur_wdata  = '0;
      cur_crd    = '0;
      busy_until = -10;
      pend_v     = 1'b0;
   endtask

   // latest value the CPU has written to an address, ignoring this cycle's write
   function automatic logic [N-1:0] lookup(input logic [AW-1:0] a);
      for (int i = q.size() - 1; i >= 0; i--)
         if (q[i].a == a) return q[i].d;
      return ram_m[a];
   endfunction

   task automatic step(input bit we, input bit re, input logic [AW-1:0] ca,
                       input logic [N-1:0] cd, input bit vr, input logic [AW-1:0] va);
      bit  full, direct;
      wr_t e;
      int  ns, vs;
      if (pend_v) begin
         ram_m[pend_a] = pend_d;
         pend_v = 1'b0;
      end
      full   = (q.size() == DEPTH);
      direct = 1'b0;
      ns = (cyc + 1) % 8;
      vs = (cyc + 3) % 8;
      ring[ns].mem_we = 1'b0;
      if (vr) begin
         cur_addr     = va;
         ring[vs].vv  = 1'b1;
         ring[vs].vd  = lookup(va);
      end else if (re && !we && q.size() == 0 && cyc > busy_until) begin
         cur_addr    = ca;
         ring[vs].cv = 1'b1;
         ring[vs].cd = ram_m[ca];
         busy_until  = cyc + 3;
      end else if (q.size() > 0 || we) begin
         if (q.size() > 0) e = q.pop_front();
         else begin
            e = '{a: ca, d: cd};
            direct = 1'b1;
         end
         cur_addr        = e.a;
         cur_wdata       = e.d;
         ring[ns].mem_we = 1'b1;
         pend_v = 1'b1;
         pend_a = e.a;
         pend_d = e.d;
      end
      ring[ns].mem_a = cur_addr;
      ring[ns].mem_d = cur_wdata;
      if (we && !full && !direct) q.push_back('{a: ca, d: cd});
   endtask

   // One clock cycle: compare registered outputs, drive inputs, compare stall, advance model
   task automatic cycle(input bit rst, input bit we, input bit re, input logic [AW-1:0] ca,
                        input logic [N-1:0] cd, input bit vr, input logic [AW-1:0] va);
      slot_t s;
      bit    exp_stall;
      @(negedge clk);
      cyc++;
      s = ring[cyc % 8];
      if (s.cv) cur_crd = s.cd;
      chk("mem_we", N'(mem_we), N'(s.mem_we));
      chk("mem_address", N'(mem_address), N'(s.mem_a));
      if (s.mem_we) chk("mem_wdata", mem_wdata, s.mem_d);
      chk("vga_valid", N'(vga_valid), N'(s.vv));
      if (s.vv) chk("vga_data", vga_data, s.vd);
      chk("cpu_rvalid", N'(cpu_rvalid), N'(s.cv));
      chk("cpu_rdata", cpu_rdata, cur_crd);
      reset = rst; cpu_we = we; cpu_re = re; cpu_address = ca; cpu_data = cd;
      vga_req = vr; vga_address = va;
      if (rst) model_reset();
      #1;
      if (rst) begin
         chk("rst_mem_we", N'(mem_we), '0);
         chk("rst_mem_address", N'(mem_address), '0);
         chk("rst_vga_valid", N'(vga_valid), '0);
         chk("rst_cpu_rvalid", N'(cpu_rvalid), '0);
         chk("rst_cpu_rdata", cpu_rdata, '0);
      end
      exp_stall = (we && q.size() == DEPTH) || (re && !(s.cv && !rst));
      chk("cpu_stall", N'(cpu_stall), N'(exp_stall));
      last_stall = exp_stall;
      if (!rst) step(we, re, ca, cd, vr, va);
      ring[cyc % 8].vv = 1'b0;
      ring[cyc % 8].cv = 1'b0;
   endtask

   task automatic idle();
      cycle(0, 0, 0, '0, '0, 0, '0);
   endtask

   initial begin
      logic [N-1:0]  wd [6];
      logic [AW-1:0] ha;
      logic [N-1:0]  hd;
      bit            hw, hr, vr;
      int            lat, mw, cnt, wi, pct, r;

      reset = 1'b1; cpu_we = 0; cpu_re = 0; cpu_address = '0; cpu_data = '0;
      vga_req = 0; vga_address = '0; ram_load = 1'b1;
      for (int i = 0; i < WORDS; i++) ram_init[i] = $urandom;
      ram_init[3] = '0;
      for (int i = 0; i < WORDS; i++) ram_m[i] = ram_init[i];
      last_stall = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1 ram_load = 1'b0;
      cycle(1, 0, 0, '0, '0, 0, '0);
      cycle(1, 0, 0, '0, '0, 0, '0);
      idle();

      // Idle write goes straight to VRAM, then read it back
      cycle(0, 1, 0, 6'h15, 32'hA5A5A5A5, 0, '0);
      idle();
      chk("t2_mem_we", N'(mem_we), 32'd1);
      chk("t2_mem_addr", N'(mem_address), 32'h15);
      idle();
      chk("t2_mem_we_once", N'(mem_we), 32'd0);
      lat = -1;
      for (int k = 0; k < 10; k++) begin
         cycle(0, 0, 1, 6'h15, '0, 0, '0);
         if (cpu_rvalid) begin lat = k; break; end
      end
      chk("t2_rd_latency", N'(lat), 32'd3);
      chk("t2_rdata", cpu_rdata, 32'hA5A5A5A5);
      idle();

      // Forwarding returns the youngest buffered write
      cycle(0, 1, 0, 6'd3, 32'h1234, 1, 6'd10);
      cycle(0, 1, 0, 6'd3, 32'h5678, 1, 6'd11);
      cycle(0, 0, 0, '0, '0, 1, 6'd3);
      idle(); idle(); idle();
      chk("t4_fwd_valid", N'(vga_valid), 32'd1);
      chk("t4_fwd_data", vga_data, 32'h5678);
      idle(); idle();

      // VGA burst with five writes: four buffered, fifth stalls, then full+drain
      for (int i = 0; i < 6; i++) wd[i] = $urandom;
      wi = 0; mw = 0;
      for (int k = 0; k < 10; k++) begin
         cycle(0, wi < 5, 0, AW'(32 + wi), wd[wi], 1, AW'(k));
         mw += int'(mem_we);
         if (k == 4) chk("t3_stall_5th", N'(cpu_stall), 32'd1);
         if (!last_stall && wi < 5) wi++;
      end
      cycle(0, 1, 0, AW'(36), wd[4], 0, '0);
      mw += int'(mem_we);
      chk("t6_full_refused", N'(cpu_stall), 32'd1);
      cycle(0, 1, 0, AW'(36), wd[4], 0, '0);
      chk("t6_accept_next", N'(cpu_stall), 32'd0);
      chk("t3_no_mem_we_burst", N'(mw), 32'd0);
      mw = int'(mem_we);
      for (int k = 0; k < 7; k++) begin
         idle();
         mw += int'(mem_we);
      end
      chk("t3_drain_count", N'(mw), 32'd5);

      // CPU read waits for two buffered writes to drain
      cycle(0, 1, 0, 6'h30, $urandom, 1, 6'd1);
      cycle(0, 1, 0, 6'h31, $urandom, 1, 6'd2);
      lat = -1;
      for (int k = 0; k < 15; k++) begin
         cycle(0, 0, 1, 6'd7, '0, 0, '0);
         if (cpu_rvalid) begin lat = k; break; end
      end
      chk("t5_rd_latency", N'(lat), 32'd5);
      idle();

      // Reset with three buffered writes and reads in flight
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, AW'(56 + i), $urandom, 1, AW'(i));
      cycle(1, 0, 0, '0, '0, 0, '0);
      cycle(1, 0, 0, '0, '0, 0, '0);
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         idle();
         cnt += int'(mem_we) + int'(vga_valid) + int'(cpu_rvalid);
      end
      chk("t1_quiet_after_reset", N'(cnt), 32'd0);
      cycle(0, 0, 0, '0, '0, 1, 6'd56);
      idle(); idle(); idle();

      // Randomized traffic
      hw = 0; hr = 0; ha = '0; hd = '0; pct = 0;
      for (int n = 0; n < 3000; n++) begin
         if (n % 250 == 0) begin
            case ((n / 250) % 4)
               0: pct = 85;
               1: pct = 50;
               2: pct = 15;
               default: pct = 0;
            endcase
         end
         if ($urandom_range(0, 599) == 0) begin
            cycle(1, 0, 0, '0, '0, 0, '0);
            cycle(1, 0, 0, '0, '0, 0, '0);
            hw = 0; hr = 0;
            continue;
         end
         if (!last_stall) begin
            r  = int'($urandom_range(0, 99));
            hw = (r < 30);
            hr = (r >= 30 && r < 42);
            ha = AW'($urandom_range(0, 9));
            hd = $urandom;
         end
         vr = (int'($urandom_range(0, 99)) < pct);
         cycle(0, hw, hr, ha, hd, vr, AW'($urandom_range(0, 9)));
      end
      for (int k = 0; k < 8; k++) idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
